// File: rtl/gpioemu_pkg.sv
// Shared types and limits for the gpioemu multiply scheduler and its datapath.
// Holds the scheduler state encoding, the default operand width and the requester bound.
package gpioemu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int MAX_NREQ  = 8;

endpackage

// File: rtl/gpioemu_mul_core.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle after start_i.
// Build option GPIOEMU_MUL_EARLY_EXIT_EN stops as soon as the remaining multiplier bits are zero.
module gpioemu_mul_core
    import gpioemu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_final_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               last_iter;

`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
    // Last iteration when this shift leaves no multiplier bits behind.
    assign last_iter = (cnt_q == CW'(WIDTH - 1)) || (b_q[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

    assign done_o       = run_q && last_iter;
    assign prod_final_o = prod_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start_i) begin
            a_d    = {{WIDTH{1'b0}}, a_i};
            b_d    = b_i;
            prod_d = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (b_q[0]) begin
                prod_d = prod_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/gpioemu_mul_sched.sv
// Round-robin arbiter and IDLE/RUN/DONE sequencer sharing one gpioemu_mul_core among NREQ requesters.
// Honours build option GPIOEMU_MUL_EARLY_EXIT_EN through the core (shorter RUN phase).
module gpioemu_mul_sched
    import gpioemu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]        resp_result,
    output logic                    resp_ovf,
    output logic                    busy,
    output sched_state_e            dbg_state
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e       state_q;
    logic [GW-1:0]      grant_q, last_grant_q;
    logic [NREQ-1:0]    resp_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;

    logic [GW-1:0]      grant, cand;
    logic               found, accept, core_done;
    int                 idx;
    logic [2*WIDTH-1:0] prod_final;

    // Search order starts just after the last served requester.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = GW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Handshake: a request transfers on the edge where req_valid[i] and req_ready[i] are both high;
    // ready is offered only in IDLE, and resp_valid is a one-cycle strobe with no back-pressure.
    assign accept    = (state_q == ST_IDLE) && found && !reset;
    assign req_ready = accept ? (NREQ'(1) << grant) : '0;

    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign resp_ovf    = ovf_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

    gpioemu_mul_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .start_i      (accept),
        .a_i          (req_a[int'(grant)*WIDTH +: WIDTH]),
        .b_i          (req_b[int'(grant)*WIDTH +: WIDTH]),
        .done_o       (core_done),
        .prod_final_o (prod_final)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            resp_valid_q <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q <= grant;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= NREQ'(1) << grant_q;
                        result_q     <= prod_final[WIDTH-1:0];
                        ovf_q        <= |prod_final[2*WIDTH-1:WIDTH];
                    end
                end
                ST_DONE: begin
                    resp_valid_q <= '0;
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpioemu_mul_sched.sv
// Self-checking bench for gpioemu_mul_sched: directed literal cases plus randomized traffic
// against a transaction-level model (product = a*b, fixed latency, round-robin grant).
module tb_gpioemu_mul_sched;
    import gpioemu_pkg::*;

    localparam int N = 2;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready, resp_valid;
    logic [W-1:0]     resp_result;
    logic             resp_ovf, busy;
    sched_state_e     dbg_state;

    always #5 clk = ~clk;

    gpioemu_mul_sched #(.NREQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_ovf    (resp_ovf),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model state: one operation in flight, its product queued until the response cycle.
    logic [2*W-1:0] exp_q[$];
    bit             m_busy = 1'b0;
    int             m_done_cyc = 0;
    int             m_gid = 0;
    int             m_last = N - 1;
    logic [W-1:0]   m_res = '0;
    logic           m_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT event within bound (t=%0t)", name, $time);
    endtask

    function automatic int arb(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Cycles spent in RUN for a given multiplier.
    function automatic int run_len(input logic [W-1:0] b);
`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
`else
        return W;
`endif
    endfunction

    always @(negedge clk) begin
        logic [N-1:0]   e_ready, e_rv;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;
        bit             done_now;
        int             g;
        done_now = m_busy && (cyc == m_done_cyc);
        if (done_now && exp_q.size() > 0) begin
            p     = exp_q[0];
            m_res = p[W-1:0];
            m_ovf = |p[2*W-1:W];
        end
        g       = arb(req_valid, m_last);
        e_ready = (!m_busy && !reset && g >= 0) ? (N'(1) << g) : '0;
        e_rv    = done_now ? (N'(1) << m_gid) : '0;
        if (chk_en) begin
            chk("req_ready", req_ready, e_ready);
            chk("resp_valid", resp_valid, e_rv);
            chk("busy", busy, m_busy);
            chk("resp_result", resp_result, m_res);
            chk("resp_ovf", resp_ovf, m_ovf);
        end
        if (reset) begin
            m_busy = 1'b0;
            m_last = N - 1;
            m_res  = '0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else if (done_now) begin
            m_busy = 1'b0;
            m_last = m_gid;
            void'(exp_q.pop_front());
        end else if (!m_busy && g >= 0) begin
            a          = req_a[g*W +: W];
            b          = req_b[g*W +: W];
            m_busy     = 1'b1;
            m_gid      = g;
            m_done_cyc = cyc + run_len(b) + 1;
            exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        end
        cyc++;
    end

    // Presents one request, waits for its response; lat counts cycles from the accept cycle.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic ovf, output int lat, output int gid);
        int n;
        @(posedge clk); #1;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready[id] !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) timeout_fail("op_ready");
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (resp_valid == '0 && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 100) timeout_fail("op_resp");
        res = resp_result;
        ovf = resp_ovf;
        gid = resp_valid[1] ? 1 : 0;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 255));
            1:       return '0;
            2:       return W'(1) << $urandom_range(0, W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res;
        logic         ovf;
        int           lat, gid, n, got;
        logic [N-1:0] seen;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_ovf", resp_ovf, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        run_op(0, 32'd2, 32'd8, res, ovf, lat, gid);
        chk("op1_result", res, 32'h10);
        chk("op1_ovf", ovf, 0);
        chk("op1_gid", gid, 0);
`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
        chk("op1_lat", lat, 5);
`else
        chk("op1_lat", lat, 33);
`endif

        run_op(1, 32'h10, 32'h80, res, ovf, lat, gid);
        chk("op2_result", res, 32'h800);
        chk("op2_ovf", ovf, 0);
        chk("op2_gid", gid, 1);
`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
        chk("op2_lat", lat, 9);
`else
        chk("op2_lat", lat, 33);
`endif

        run_op(0, 32'h80000, 32'h8007, res, ovf, lat, gid);
        chk("op3_result", res, 32'h0038_0000);
        chk("op3_ovf", ovf, 1);
        chk("op3_gid", gid, 0);
`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
        chk("op3_lat", lat, 17);
`else
        chk("op3_lat", lat, 33);
`endif

        run_op(1, 32'h1234, 32'd0, res, ovf, lat, gid);
        chk("op4_result", res, 0);
        chk("op4_ovf", ovf, 0);
`ifdef GPIOEMU_MUL_EARLY_EXIT_EN
        chk("op4_lat", lat, 2);
`else
        chk("op4_lat", lat, 33);
`endif

        // Both requesters held valid: grants must alternate starting at 0.
        @(posedge clk); #1;
        req_a     = {32'd5, 32'd3};
        req_b     = {32'd7, 32'd9};
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (n >= 200) timeout_fail("rot_ready");
            got = req_ready[1] ? 1 : 0;
            chk("rot_grant", got, k % 2);
            n = 0;
            @(negedge clk);
            while (resp_valid == '0 && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (n >= 200) timeout_fail("rot_resp");
            chk("rot_resp_onehot", resp_valid, (k % 2) ? 2'b10 : 2'b01);
            chk("rot_result", resp_result, (k % 2) ? 32'd35 : 32'd27);
        end
        @(posedge clk); #1 req_valid = '0;

        // Reset in the middle of RUN discards the operation and restores priority to 0.
        run_op(0, 32'd3, 32'd5, res, ovf, lat, gid);
        chk("pre_rst_result", res, 32'd15);
        @(posedge clk); #1;
        req_a[0 +: W] = 32'd7;
        req_b[0 +: W] = 32'hFFFF;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        chk("pre_rst_ready", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = '1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_resp_valid", resp_valid, 0);
        chk("post_rst_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0;

        // Randomized traffic with withdrawals and occasional resets.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            seen = req_ready;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && seen[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_a[i*W +: W] = rnd_operand();
                    req_b[i*W +: W] = rnd_operand();
                    req_valid[i]    = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = '0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpioemu_mul_sched.md
# gpioemu_mul_sched

Round-robin scheduler sharing one iterative shift-add multiplier among NREQ requesters in the gpioemu peripheral. Sits between the register/GPIO front-ends (bus-side and gpio-side operand latches) and the multiply datapath. Accepts one operand pair at a time, runs the multiplication, and returns a truncated product with an overflow flag to the granted requester.

## Interface
- NREQ, 2: number of requesters (2..8)
- WIDTH, 32: operand and result width
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  operand pair i presented
- req_a  in  NREQ*WIDTH  multiplicand i, slice [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  multiplier i
- req_ready  out  NREQ  one-hot accept strobe
- resp_valid  out  NREQ  one-hot, one-cycle result strobe
- resp_result  out  WIDTH  low WIDTH bits of product, shared by all requesters
- resp_ovf  out  1  any of the upper WIDTH product bits set
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: grant = first i with req_valid[i], searching last_grant+1, last_grant+2, … modulo NREQ. req_ready[grant] = 1 combinationally, so accept happens the same cycle. The accept edge latches A into a 2*WIDTH register, B into a shift register, clears the product and cnt, and moves to RUN. With no valid request, the block stays in IDLE.
- RUN: each cycle, if B[0] then product += A. Then A <<= 1, B >>= 1, cnt++. After iteration WIDTH (cnt == WIDTH), move to DONE.
- DONE: resp_valid[grant_q] = 1 for exactly one cycle. resp_result = product[WIDTH-1:0] and resp_ovf = |product[2*WIDTH-1:WIDTH]. last_grant <= grant_q. Move to IDLE. There is no response back-pressure.
- resp_result and resp_ovf hold their value until the next DONE.
- A requester holds req_valid, req_a and req_b until it sees req_ready. Dropping req_valid before ready is legal: the request is withdrawn and no response is produced.
- Operands are unsigned. The product register is 2*WIDTH wide, so no intermediate overflow is possible.

## Timing
- Reset values:
  - state IDLE, last_grant NREQ-1 (requester 0 has first priority)
  - req_ready 0, resp_valid 0, resp_result 0, resp_ovf 0, busy 0
- Per operation:
  - cycle 0: IDLE with ready high
  - cycles 1..WIDTH: RUN
  - cycle WIDTH+1: DONE with resp_valid high
  - cycle WIDTH+2: IDLE, next accept possible
- Throughput: one operation per WIDTH+2 cycles.
- req_ready is never asserted while busy. Requests arriving during RUN or DONE wait.
- Simultaneous requests: exactly one is granted. With all requesters continuously valid, grants strictly rotate.
- Reset mid-RUN or mid-DONE: the operation is discarded with no resp_valid, and all state returns to its reset value on that edge.

## Configuration
- GPIOEMU_MUL_EARLY_EXIT_EN defined:
  - RUN also exits to DONE after the iteration that leaves the shifted B equal to 0.
  - Latency becomes (index of B's highest set bit + 1) RUN cycles.
  - B == 0 still takes one RUN cycle.
- Undefined: RUN always lasts exactly WIDTH cycles. Results are identical either way.

## Structure
- gpioemu_pkg holds the state enum (IDLE/RUN/DONE), default WIDTH, and the NREQ upper bound.
- Sub-module gpioemu_mul_core holds the iterative datapath: the A/B/product registers, cnt, a start input, and a done output.
- gpioemu_mul_sched holds the arbiter, grant_q, last_grant and the FSM.

## Test plan
- Req0 a=2, b=8: resp_valid[0] at cycle 33 (WIDTH=32), result 0x10, ovf 0.
- Req1 a=0x10, b=0x80: resp_valid[1], result 0x800, ovf 0. last_grant becomes 1.
- Req0 a=0x80000, b=0x8007: result 0x00380000, ovf 1.
- Both requesters held valid for 4 operations: grant order 0,1,0,1, each response one-hot to the matching requester.
- Reset asserted at RUN cycle 10: no resp_valid, busy 0 the next cycle, and the next request is granted to requester 0.
- With GPIOEMU_MUL_EARLY_EXIT_EN:
  - a=2, b=8 gives resp_valid at cycle 5, result 0x10.
  - b=0 gives resp_valid at cycle 2, result 0.
